// File: rtl/seq_alu_pkg.sv
// seq_alu_pkg: shared opcode/state enums and flag indices for seq_alu_core.
package seq_alu_pkg;
   typedef enum logic [3:0] {
      OP_ADD  = 4'd0,  OP_SUB  = 4'd1,  OP_AND  = 4'd2,  OP_OR   = 4'd3,
      OP_XOR  = 4'd4,  OP_NOT  = 4'd5,  OP_SHR  = 4'd6,  OP_SHL  = 4'd7,
      OP_ADC  = 4'd8,  OP_SBB  = 4'd9,  OP_MUL  = 4'd10, OP_MULH = 4'd11,
      OP_CMP  = 4'd12, OP_PASS = 4'd13, OP_ASR  = 4'd14, OP_RSV  = 4'd15
   } opcode_e;

   localparam int FLAG_V = 3;
   localparam int FLAG_C = 2;
   localparam int FLAG_N = 1;
   localparam int FLAG_Z = 0;

   typedef enum logic [1:0] {S_IDLE, S_MUL, S_DONE} state_e;

   // Single-cycle path only; MUL/MULH reach here solely when the multiplier is absent.
   function automatic logic writes_acc(opcode_e op);
      return !(op inside {OP_CMP, OP_RSV, OP_MUL, OP_MULH});
   endfunction

   function automatic logic is_reserved(opcode_e op);
      return op inside {OP_RSV, OP_MUL, OP_MULH};
   endfunction
endpackage

// File: rtl/seq_alu_core_if.sv
// seq_alu_core_if: operand/result handshake bundle between producer/consumer and the ALU core.
interface seq_alu_core_if #(parameter int WIDTH = 8);
   logic             in_valid;
   logic             in_ready;
   logic [3:0]       opcode;
   logic             use_acc;
   logic [WIDTH-1:0] op_a;
   logic [WIDTH-1:0] op_b;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] result;
   logic [3:0]       flags;
   logic [WIDTH-1:0] acc;

   modport master (
      output in_valid, opcode, use_acc, op_a, op_b, out_ready,
      input  in_ready, out_valid, result, flags, acc
   );

   modport slave (
      input  in_valid, opcode, use_acc, op_a, op_b, out_ready,
      output in_ready, out_valid, result, flags, acc
   );
endinterface

// File: rtl/seq_alu_mult.sv
// seq_alu_mult: WIDTH-step right-shifting shift-add multiplier, one step per enabled cycle.
module seq_alu_mult #(
   parameter int WIDTH = 8
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               ena_i,
   input  logic               start_i,
   input  logic [WIDTH-1:0]   a_i,
   input  logic [WIDTH-1:0]   b_i,
   output logic               done_o,
   output logic [2*WIDTH-1:0] prod_o
);
   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   logic [WIDTH-1:0]   a_q, b_q;
   logic [2*WIDTH-1:0] prod_q, prod_d;
   logic [CW-1:0]      cnt_q;
   logic               busy_q;
   logic [WIDTH:0]     sum;

   // Add into the upper half, then shift the whole product right; low bits collect the finished LSBs.
   always_comb begin
      sum    = {1'b0, prod_q[2*WIDTH-1:WIDTH]} + (b_q[0] ? {1'b0, a_q} : '0);
      prod_d = {sum, prod_q[WIDTH-1:1]};
   end

   assign done_o = busy_q & ena_i & (cnt_q == CW'(WIDTH - 1));
   assign prod_o = prod_d;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_q    <= '0;
         b_q    <= '0;
         prod_q <= '0;
         cnt_q  <= '0;
         busy_q <= 1'b0;
      end else if (ena_i) begin
         if (start_i) begin
            a_q    <= a_i;
            b_q    <= b_i;
            prod_q <= '0;
            cnt_q  <= '0;
            busy_q <= 1'b1;
         end else if (busy_q) begin
            prod_q <= prod_d;
            b_q    <= b_q >> 1;
            cnt_q  <= cnt_q + 1'b1;
            if (done_o) busy_q <= 1'b0;
         end
      end
   end
endmodule

// File: rtl/seq_alu_core.sv
// seq_alu_core: handshaked sequential ALU with accumulator, registered {V,C,N,Z} flags
// and an optional multi-cycle multiplier.
module seq_alu_core
   import seq_alu_pkg::*;
#(
   parameter int WIDTH  = 8,
   parameter bit MUL_EN = 1'b1
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          ena,
   seq_alu_core_if.slave bus
);
   state_e             state_q;
   logic [WIDTH-1:0]   result_q, acc_q;
   logic [3:0]         flags_q;
   logic               out_valid_q, mulh_q;

   opcode_e            op;
   logic [WIDTH-1:0]   a, b;
   logic               cin, accept, is_mul;
   logic [WIDTH:0]     add_s, sub_s;
   logic [WIDTH-1:0]   alu_res;
   logic               alu_c, alu_v;
   logic [3:0]         alu_flags;

   logic               mul_done, mul_hnz;
   logic [2*WIDTH-1:0] prod;
   logic [WIDTH-1:0]   mul_res;
   logic [3:0]         mul_flags;

   assign op     = opcode_e'(bus.opcode);
   assign a      = bus.use_acc ? acc_q : bus.op_a;
   assign b      = bus.op_b;
   assign cin    = flags_q[FLAG_C];
   assign is_mul = MUL_EN && (op == OP_MUL || op == OP_MULH);
   assign accept = ena & bus.in_valid & (state_q == S_IDLE);

   always_comb begin
      add_s   = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin & (op == OP_ADC)};
      sub_s   = {1'b0, a} - {1'b0, b} - {{WIDTH{1'b0}}, cin & (op == OP_SBB)};
      alu_res = '0;
      alu_c   = 1'b0;
      alu_v   = 1'b0;
      case (op)
         OP_ADD, OP_ADC: begin
            alu_res = add_s[WIDTH-1:0];
            alu_c   = add_s[WIDTH];
            alu_v   = (a[WIDTH-1] == b[WIDTH-1]) && (alu_res[WIDTH-1] != a[WIDTH-1]);
         end
         OP_SUB, OP_SBB, OP_CMP: begin
            alu_res = sub_s[WIDTH-1:0];
            alu_c   = sub_s[WIDTH];
            alu_v   = (a[WIDTH-1] != b[WIDTH-1]) && (alu_res[WIDTH-1] != a[WIDTH-1]);
         end
         OP_AND:  alu_res = a & b;
         OP_OR:   alu_res = a | b;
         OP_XOR:  alu_res = a ^ b;
         OP_NOT:  alu_res = ~a;
         OP_PASS: alu_res = b;
         OP_SHR: begin
            alu_res = {1'b0, a[WIDTH-1:1]};
            alu_c   = a[0];
         end
         OP_SHL: begin
            alu_res = {a[WIDTH-2:0], 1'b0};
            alu_c   = a[WIDTH-1];
         end
         OP_ASR: begin
            alu_res = {a[WIDTH-1], a[WIDTH-1:1]};
            alu_c   = a[0];
         end
         default: alu_res = '0;
      endcase
      alu_flags = is_reserved(op) ? 4'b0000 : {alu_v, alu_c, alu_res[WIDTH-1], alu_res == '0};
   end

   generate
      if (MUL_EN) begin : g_mul
         seq_alu_mult #(.WIDTH(WIDTH)) u_mult (
            .clk     (clk),
            .rst_n   (rst_n),
            .ena_i   (ena),
            .start_i (accept & is_mul),
            .a_i     (a),
            .b_i     (b),
            .done_o  (mul_done),
            .prod_o  (prod)
         );
      end else begin : g_nomul
         assign mul_done = 1'b0;
         assign prod     = '0;
      end
   endgenerate

   assign mul_res   = mulh_q ? prod[2*WIDTH-1:WIDTH] : prod[WIDTH-1:0];
   assign mul_hnz   = |prod[2*WIDTH-1:WIDTH];
   assign mul_flags = {mul_hnz, mul_hnz, mul_res[WIDTH-1], mul_res == '0};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         result_q    <= '0;
         flags_q     <= '0;
         acc_q       <= '0;
         out_valid_q <= 1'b0;
         mulh_q      <= 1'b0;
      end else if (ena) begin
         case (state_q)
            S_IDLE: if (bus.in_valid) begin
               if (is_mul) begin
                  mulh_q  <= (op == OP_MULH);
                  state_q <= S_MUL;
               end else begin
                  result_q    <= alu_res;
                  flags_q     <= alu_flags;
                  if (writes_acc(op)) acc_q <= alu_res;
                  out_valid_q <= 1'b1;
                  state_q     <= S_DONE;
               end
            end
            S_MUL: if (mul_done) begin
               result_q    <= mul_res;
               flags_q     <= mul_flags;
               acc_q       <= mul_res;
               out_valid_q <= 1'b1;
               state_q     <= S_DONE;
            end
            S_DONE: if (bus.out_ready) begin
               out_valid_q <= 1'b0;
               state_q     <= S_IDLE;
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign bus.in_ready  = ena & (state_q == S_IDLE);
   assign bus.out_valid = out_valid_q;
   assign bus.result    = result_q;
   assign bus.flags     = flags_q;
   assign bus.acc       = acc_q;
endmodule

// File: tb/tb_seq_alu_core.sv
// tb_seq_alu_core: directed vector table plus hand-written multi-cycle sequences for seq_alu_core.
module tb_seq_alu_core;
   import seq_alu_pkg::*;

   typedef struct {
      logic [3:0] op;
      logic       ua;
      logic [7:0] a;
      logic [7:0] b;
      logic [7:0] res;
      logic [3:0] fl;
      logic [7:0] acc;
      int         lat;
   } vec_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic ena = 1'b1;
   int   n_vec = 0;
   int   n_bad = 0;
   vec_t vt[25];

   seq_alu_core_if #(.WIDTH(8)) bus ();

   seq_alu_core #(.WIDTH(8), .MUL_EN(1'b1)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .ena   (ena),
      .bus   (bus.slave)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
      end
   endtask

   task automatic start(input logic [3:0] op, input logic ua, input logic [7:0] a, input logic [7:0] b);
      int k = 0;
      while (!bus.in_ready && k < 50) begin
         @(posedge clk); #1; k++;
      end
      chk("in_ready_wait", 32'(bus.in_ready), 32'd1);
      bus.opcode   = op;
      bus.use_acc  = ua;
      bus.op_a     = a;
      bus.op_b     = b;
      bus.in_valid = 1'b1;
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
   endtask

   task automatic wait_out(inout int lat);
      while (!bus.out_valid && lat < 60) begin
         @(posedge clk); #1; lat++;
      end
      chk("out_valid_wait", 32'(bus.out_valid), 32'd1);
   endtask

   task automatic ack();
      bus.out_ready = 1'b1;
      @(posedge clk); #1;
      bus.out_ready = 1'b0;
   endtask

   task automatic do_vec(input vec_t v, input int idx);
      int lat = 1;
      start(v.op, v.ua, v.a, v.b);
      wait_out(lat);
      chk($sformatf("v%0d_lat", idx), 32'(lat), 32'(v.lat));
      chk($sformatf("v%0d_res", idx), 32'(bus.result), 32'(v.res));
      chk($sformatf("v%0d_flags", idx), 32'(bus.flags), 32'(v.fl));
      chk($sformatf("v%0d_acc", idx), 32'(bus.acc), 32'(v.acc));
      ack();
   endtask

   initial begin
      int   lat;
      logic seen;
      vt = '{
         '{OP_ADD,  1'b0, 8'h0F, 8'h01, 8'h10, 4'b0000, 8'h10, 1},
         '{OP_ADD,  1'b0, 8'hFF, 8'h01, 8'h00, 4'b0101, 8'h00, 1},
         '{OP_ADC,  1'b0, 8'h00, 8'h00, 8'h01, 4'b0000, 8'h01, 1},
         '{OP_MUL,  1'b0, 8'h12, 8'h34, 8'hA8, 4'b1110, 8'hA8, 9},
         '{OP_MULH, 1'b0, 8'h12, 8'h34, 8'h03, 4'b1100, 8'h03, 9},
         '{OP_PASS, 1'b0, 8'h00, 8'h05, 8'h05, 4'b0000, 8'h05, 1},
         '{OP_SUB,  1'b1, 8'h00, 8'h07, 8'hFE, 4'b0110, 8'hFE, 1},
         '{OP_CMP,  1'b1, 8'h00, 8'hFE, 8'h00, 4'b0001, 8'hFE, 1},
         '{OP_AND,  1'b0, 8'hF0, 8'h3C, 8'h30, 4'b0000, 8'h30, 1},
         '{OP_OR,   1'b0, 8'hF0, 8'h0C, 8'hFC, 4'b0010, 8'hFC, 1},
         '{OP_XOR,  1'b0, 8'hFF, 8'hFF, 8'h00, 4'b0001, 8'h00, 1},
         '{OP_NOT,  1'b0, 8'h0F, 8'h00, 8'hF0, 4'b0010, 8'hF0, 1},
         '{OP_SHR,  1'b0, 8'h81, 8'h00, 8'h40, 4'b0100, 8'h40, 1},
         '{OP_SHL,  1'b0, 8'h81, 8'h00, 8'h02, 4'b0100, 8'h02, 1},
         '{OP_ASR,  1'b0, 8'h81, 8'h00, 8'hC0, 4'b0110, 8'hC0, 1},
         '{OP_ADD,  1'b0, 8'h7F, 8'h01, 8'h80, 4'b1010, 8'h80, 1},
         '{OP_SUB,  1'b0, 8'h80, 8'h01, 8'h7F, 4'b1000, 8'h7F, 1},
         '{OP_SUB,  1'b0, 8'h00, 8'h01, 8'hFF, 4'b0110, 8'hFF, 1},
         '{OP_SBB,  1'b0, 8'h05, 8'h03, 8'h01, 4'b0000, 8'h01, 1},
         '{OP_RSV,  1'b0, 8'h12, 8'h34, 8'h00, 4'b0000, 8'h01, 1},
         '{OP_ADC,  1'b1, 8'h00, 8'hFF, 8'h00, 4'b0101, 8'h00, 1},
         '{OP_ADC,  1'b1, 8'h00, 8'h00, 8'h01, 4'b0000, 8'h01, 1},
         '{OP_MUL,  1'b0, 8'hFF, 8'hFF, 8'h01, 4'b1100, 8'h01, 9},
         '{OP_MUL,  1'b0, 8'h03, 8'h05, 8'h0F, 4'b0000, 8'h0F, 9},
         '{OP_MUL,  1'b0, 8'h00, 8'h37, 8'h00, 4'b0001, 8'h00, 9}
      };
      bus.in_valid  = 1'b0;
      bus.opcode    = 4'd0;
      bus.use_acc   = 1'b0;
      bus.op_a      = 8'h00;
      bus.op_b      = 8'h00;
      bus.out_ready = 1'b0;
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
      chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
      chk("rst_result", 32'(bus.result), 32'd0);
      chk("rst_flags", 32'(bus.flags), 32'd0);
      chk("rst_acc", 32'(bus.acc), 32'd0);
      ena = 1'b0;
      #1 chk("ena_low_in_ready", 32'(bus.in_ready), 32'd0);
      ena = 1'b1;
      @(posedge clk); #1;

      for (int i = 0; i < 25; i++) do_vec(vt[i], i);

      // Backpressure: result held, new request ignored while DONE waits.
      lat = 1;
      start(OP_ADD, 1'b0, 8'h01, 8'h02);
      wait_out(lat);
      bus.opcode   = OP_PASS;
      bus.op_b     = 8'hAA;
      bus.in_valid = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(posedge clk); #1;
         chk("bp_result", 32'(bus.result), 32'h03);
         chk("bp_in_ready", 32'(bus.in_ready), 32'd0);
         chk("bp_out_valid", 32'(bus.out_valid), 32'd1);
      end
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
      @(posedge clk); #1;
      bus.out_ready = 1'b0;
      chk("bp_rel_out_valid", 32'(bus.out_valid), 32'd0);
      chk("bp_rel_in_ready", 32'(bus.in_ready), 32'd1);
      chk("bp_rel_result", 32'(bus.result), 32'h03);
      chk("bp_rel_acc", 32'(bus.acc), 32'h03);

      // ena low for 4 cycles mid-multiply stretches latency by 4.
      lat = 1;
      start(OP_MUL, 1'b0, 8'hFF, 8'hFF);
      repeat (3) begin
         @(posedge clk); #1; lat++;
      end
      ena = 1'b0;
      repeat (4) begin
         @(posedge clk); #1; lat++;
      end
      chk("ena_freeze_out_valid", 32'(bus.out_valid), 32'd0);
      chk("ena_freeze_in_ready", 32'(bus.in_ready), 32'd0);
      ena = 1'b1;
      wait_out(lat);
      chk("ena_mul_lat", 32'(lat), 32'd13);
      chk("ena_mul_res", 32'(bus.result), 32'h01);
      chk("ena_mul_flags", 32'(bus.flags), 32'hC);
      ack();

      // Abort during multiply step 4 via async reset.
      start(OP_MUL, 1'b0, 8'h12, 8'h34);
      repeat (4) @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("abort_out_valid", 32'(bus.out_valid), 32'd0);
      chk("abort_result", 32'(bus.result), 32'd0);
      chk("abort_flags", 32'(bus.flags), 32'd0);
      chk("abort_acc", 32'(bus.acc), 32'd0);
      @(posedge clk); #1 rst_n = 1'b1;
      seen = 1'b0;
      repeat (15) begin
         @(posedge clk); #1; seen |= bus.out_valid;
      end
      chk("abort_no_output", 32'(seen), 32'd0);
      do_vec('{OP_ADC, 1'b1, 8'h00, 8'h05, 8'h05, 4'b0000, 8'h05, 1}, 99);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end
endmodule

// File: doc/seq_alu_core.md
# seq_alu_core

Parametrised sequential ALU core: the next generation of the team's 4-bit pin-mapped ALU. It adds these features:
- a valid/ready operand handshake;
- an optional accumulator as operand A;
- a registered flag set;
- carry-chained ops;
- a multi-cycle shift-add multiplier.

It sits behind the chip pin wrapper, which unpacks the pin buses into this interface.

## Interface
- WIDTH, 8, operand/result width (≥4)
- MUL_EN, 1, 1 = include multiplier; 0 = MUL/MULH behave as reserved opcode
- clk  input  1  clock, all state on rising edge
- rst_n  input  1  asynchronous active-low reset
- ena  input  1  design enable; low freezes all state, forces in_ready=0
- in_valid  input  1  operand/opcode presented
- in_ready  output  1  core accepts on in_valid&in_ready
- opcode  input  4  operation select
- use_acc  input  1  1 = operand A taken from accumulator, op_a ignored
- op_a  input  WIDTH  operand A
- op_b  input  WIDTH  operand B
- out_valid  output  1  result/flags valid
- out_ready  input  1  consumer takes result on out_valid&out_ready
- result  output  WIDTH  registered result
- flags  output  4  {V,C,N,Z} registered
- acc  output  WIDTH  current accumulator

## Operation
Opcodes (A = op_a or acc, cin = stored C flag):
- 0 ADD A+B
- 1 SUB A−B
- 2 AND
- 3 OR
- 4 XOR
- 5 NOT A
- 6 SHR A logical by 1
- 7 SHL A by 1
- 8 ADC A+B+cin
- 9 SBB A−B−cin
- 10 MUL low WIDTH bits of A×B (unsigned)
- 11 MULH high WIDTH bits
- 12 CMP: flags of A−B, result=A−B, acc unchanged
- 13 PASS B
- 14 ASR A by 1
- 15 reserved: result=0, flags=0, acc unchanged

Flags:
- Z: result==0.
- N: result[WIDTH−1].
- C:
  - ADD/ADC: carry out.
  - SUB/SBB/CMP: borrow (1 iff A < B+cin, unsigned).
  - Shifts: bit shifted out.
  - MUL: high half ≠0.
  - Otherwise 0.
- V:
  - Add/sub family: signed overflow.
  - MUL: same as C.
  - Otherwise 0.

Accumulator:
- acc ← result on every completed op except CMP and 15.
- acc is written at result-register time, not at handshake.

FSM states IDLE, MUL, DONE:
- IDLE: in_ready=1 when ena. On accept:
  - non-MUL op: compute, register result/flags/acc, go DONE.
  - MUL/MULH with MUL_EN: latch A,B, clear 2·WIDTH product, go MUL.
- MUL: one shift-add step per cycle, counter 0..WIDTH−1. At count WIDTH−1 register result/flags/acc and go DONE.
- DONE: out_valid=1. On out_ready go IDLE. result, flags and acc stay held until the next completion.

Arithmetic widths:
- Adds/subs are computed in WIDTH+1 bits.
- Product is 2·WIDTH bits.
- No saturation.

## Timing
- Reset values: in_ready=1 (ena permitting), out_valid=0, result=0, flags=0, acc=0, state IDLE.
- Latency, accept to out_valid:
  - 1 cycle for non-MUL ops.
  - WIDTH+1 cycles for MUL/MULH.
- Throughput: at most one op per 2 cycles. in_ready is 0 in MUL and DONE.
- in_valid while in_ready=0: ignored; the producer holds its inputs.
- out_ready held high in DONE: out_valid drops the next cycle; in_ready rises the same cycle.
- ena low mid-MUL: step counter and product freeze; resume on ena high. Total latency grows by the number of ena-low cycles.
- rst_n asserted in MUL or DONE: op is aborted, all state returns to reset values asynchronously, no output produced.
- use_acc with ADC right after reset: cin=0, acc=0.

## Structure
- Package seq_alu_pkg holds:
  - opcode enum (4-bit);
  - flag bit index constants V=3, C=2, N=1, Z=0;
  - FSM state enum.
- Sub-module seq_alu_mult, instantiated only when MUL_EN=1:
  - start/done handshake, WIDTH-step shift-add, outputs 2·WIDTH product.
- The top holds the combinational single-cycle datapath, the FSM, and the result/flag/acc registers.

## Test plan
All cases use WIDTH=8.
- Reset then ADD: op_a=0x0F, op_b=0x01, use_acc=0 → after 1 cycle out_valid=1, result=0x10, flags=0000; acc=0x10.
- Carry chain: ADD 0xFF+0x01 → result 0x00, C=1, Z=1. Then ADC 0x00+0x00 → result 0x01, C=0.
- MUL 0x12×0x34 (0x03A8) → out_valid exactly 9 cycles after accept, result=0xA8, C=V=1. Then MULH same operands → 0x03.
- Backpressure: out_ready=0 for 5 cycles in DONE → result held, in_ready=0, a new in_valid is ignored. out_ready=1 → in_ready the next cycle.
- Accumulator/CMP: PASS B=0x05, then SUB use_acc B=0x07 → result 0xFE, C=1, N=1, acc=0xFE. Then CMP use_acc B=0xFE → Z=1, acc still 0xFE.
- Abort: rst_n low during MUL step 4 → out_valid, result, flags and acc=0 immediately. No out_valid after release.
